// File: rtl/custom_cntb_result_stage_if.sv
// X-IF issue/commit/result bundle between the issue stage/core and the CNTB
// result stage.
//   slave  : the result stage (takes issue + commit, drives result)
//   master : the issue stage / core side
// Signals keep the stage-side _i/_o names so they read the same at both ends.
interface custom_cntb_result_stage_if #(
  parameter int unsigned X_ID_WIDTH = 4
);
  logic                  issue_valid_i;
  logic                  issue_ready_o;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic [31:0]           issue_rs1_i;
  logic [4:0]            issue_rd_i;
  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;
  logic                  result_valid_o;
  logic                  result_ready_i;
  logic [X_ID_WIDTH-1:0] result_id_o;
  logic [4:0]            result_rd_o;
  logic                  result_we_o;
  logic [31:0]           result_data_o;

  modport slave (
    input  issue_valid_i, issue_id_i, issue_rs1_i, issue_rd_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output issue_ready_o,
    output result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o
  );

  modport master (
    output issue_valid_i, issue_id_i, issue_rs1_i, issue_rd_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  issue_ready_o,
    input  result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o
  );
endinterface

// File: rtl/custom_cntb_result_stage.sv
// CNTB result stage: population count of rs1 into rd, one instruction in
// flight, rs1 counted CHUNK_W bits per cycle, result released only after a
// matching commit (a matching kill discards the instruction).
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   xif     - issue / commit / result handshakes (slave modport)
//   busy_o  - an instruction is in flight
module custom_cntb_result_stage #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned CHUNK_W    = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  custom_cntb_result_stage_if.slave        xif,
  output logic                             busy_o
);

  localparam int unsigned NCHUNK = 32 / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, WAIT_COMMIT, RESULT} state_e;

  state_e                state_q, state_d;
  logic [X_ID_WIDTH-1:0] id_q, id_d;
  logic [4:0]            rd_q, rd_d;
  logic [31:0]           rs1_q, rs1_d;
  logic [5:0]            acc_q, acc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  committed_q, committed_d;

  logic [5:0]            chunk_cnt;
  logic                  cmt_hit;
  logic                  last_chunk;

  // rs1_q is shifted right every COUNT cycle, so the current chunk is always
  // the low CHUNK_W bits.
  always_comb begin
    chunk_cnt = '0;
    for (int unsigned i = 0; i < CHUNK_W; i++) begin
      chunk_cnt = chunk_cnt + 6'(rs1_q[i]);
    end
  end

  // In IDLE the commit may refer to the instruction being issued this cycle.
  assign cmt_hit    = xif.commit_valid_i &&
                      (xif.commit_id_i == ((state_q == IDLE) ? xif.issue_id_i : id_q));
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    committed_d = committed_q;

    unique case (state_q)
      IDLE: begin
        if (xif.issue_valid_i && !(cmt_hit && xif.commit_kill_i)) begin
          id_d        = xif.issue_id_i;
          rd_d        = xif.issue_rd_i;
          rs1_d       = xif.issue_rs1_i;
          acc_d       = '0;
          idx_d       = '0;
          committed_d = cmt_hit;
          state_d     = COUNT;
        end
      end
      COUNT: begin
        acc_d = acc_q + chunk_cnt;
        rs1_d = rs1_q >> CHUNK_W;
        idx_d = idx_q + IDX_W'(1);
        if (cmt_hit && xif.commit_kill_i) begin
          state_d = IDLE;
        end else begin
          // A commit landing on the last chunk cycle still counts.
          committed_d = committed_q || cmt_hit;
          if (last_chunk) begin
            state_d = committed_d ? RESULT : WAIT_COMMIT;
          end
        end
      end
      WAIT_COMMIT: begin
        if (cmt_hit) begin
          state_d = xif.commit_kill_i ? IDLE : RESULT;
        end
      end
      RESULT: begin
        if (xif.result_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      id_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      committed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      committed_q <= committed_d;
    end
  end

  logic res_v;
  assign res_v = (state_q == RESULT);

  // Gated with rst_ni so ready stays low for the whole reset pulse.
  assign xif.issue_ready_o  = rst_ni && (state_q == IDLE);
  assign xif.result_valid_o = res_v;
  assign xif.result_we_o    = res_v;
  assign xif.result_id_o    = res_v ? id_q : '0;
  assign xif.result_rd_o    = res_v ? rd_q : '0;
  assign xif.result_data_o  = res_v ? {26'b0, acc_q} : '0;
  assign busy_o             = (state_q != IDLE);

endmodule
